// File: rtl/rr_mux_pkg.sv
// rr_mux shared constants: select modes, default geometry
// and the channel-index width helper.
package rr_mux_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   localparam int N_CH_DEF   = 4;
   localparam int DATA_W_DEF = 8;

   localparam int N_CH_MIN   = 2;
   localparam int N_CH_MAX   = 16;
   localparam int DATA_W_MIN = 1;
   localparam int DATA_W_MAX = 64;

   function automatic int sel_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel picker: rotating priority after ptr,
// or a direct pick of sel in fixed mode.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int N_CH = N_CH_DEF
) (
   input  logic [N_CH-1:0]            req,
   input  logic [sel_width(N_CH)-1:0] ptr,
   input  logic                       mode,
   input  logic [sel_width(N_CH)-1:0] sel,
   output logic [sel_width(N_CH)-1:0] grant,
   output logic                       grant_valid
);

   localparam int SEL_W = sel_width(N_CH);

   logic [SEL_W-1:0] rr_grant;
   logic             rr_valid;
   logic             fx_valid;

   // ptr itself is visited last (i == N_CH wraps back onto it)
   always_comb begin : rr_search
      int idx;
      rr_grant = '0;
      rr_valid = 1'b0;
      idx      = 0;
      for (int i = 1; i <= N_CH; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_CH) begin
            idx = idx - N_CH;
         end
         if (!rr_valid && req[idx]) begin
            rr_valid = 1'b1;
            rr_grant = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      fx_valid = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(sel) == k && req[k]) begin
            fx_valid = 1'b1;
         end
      end
   end

   always_comb begin
      grant       = rr_grant;
      grant_valid = rr_valid;
      if (mode == MODE_FIXED) begin
         grant       = sel;
         grant_valid = fx_valid;
      end
   end

endmodule

// File: rtl/rr_mux.sv
// N-channel to one registered multiplexer with valid/ready
// handshakes and round-robin or fixed channel selection.
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter int N_CH   = N_CH_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_CH*DATA_W-1:0]     in_data,
   input  logic [N_CH-1:0]            in_valid,
   output logic [N_CH-1:0]            in_ready,
   input  logic                       mode,
   input  logic [sel_width(N_CH)-1:0] sel,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [sel_width(N_CH)-1:0] out_ch
);

   localparam int SEL_W = sel_width(N_CH);

   if (N_CH < N_CH_MIN || N_CH > N_CH_MAX ||
       DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_param
      $error("rr_mux: N_CH or DATA_W out of range");
   end

   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_ch_q, out_ch_d;

   logic [SEL_W-1:0]  grant;
   logic              grant_valid;
   logic              load;
   logic              xfer;
   logic [DATA_W-1:0] sel_data;

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .req         (in_valid),
      .ptr         (ptr_q),
      .mode        (mode),
      .sel         (sel),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign load = !out_valid_q || out_ready;
   // rst_n gates the handshake so nothing is offered during reset
   assign xfer = rst_n && load && grant_valid;

   always_comb begin
      in_ready = '0;
      for (int g = 0; g < N_CH; g++) begin
         in_ready[g] = xfer && (int'(grant) == g);
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(grant) == k) begin
            sel_data = in_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      if (load) begin
         out_valid_d = grant_valid;
         if (grant_valid) begin
            out_data_d = sel_data;
            out_ch_d   = grant;
            ptr_d      = grant;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= SEL_W'(N_CH - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter N_CH, default 4: number of input channels; legal values 2..16.
REQ-002 Parameter DATA_W, default 8: data width per channel; legal values 1..64.
REQ-003 Derived constant SEL_W = max(1, clog2(N_CH)): width of the channel index.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 in_valid  input  N_CH  per-channel valid.
REQ-008 in_ready  output  N_CH  per-channel ready; a transfer on channel k is in_valid[k] && in_ready[k] at a rising edge.
REQ-009 mode  input  1  select mode: 0 = round-robin, 1 = fixed select.
REQ-010 sel  input  SEL_W  channel index used in fixed mode; ignored in round-robin mode.
REQ-011 out_data  output  DATA_W  registered selected data.
REQ-012 out_valid  output  1  out_data holds an untaken beat.
REQ-013 out_ready  input  1  downstream accepts; a transfer is out_valid && out_ready.
REQ-014 out_ch  output  SEL_W  index of the channel that sourced out_data.

Function
REQ-015 The output register shall accept a new beat when load = !out_valid || out_ready.
REQ-016 At most one in_ready bit shall be high in any cycle: in_ready[g] = load && grant_valid && g == grant; all other bits 0.
REQ-017 Round-robin mode: grant shall be the first k with in_valid[k] high, searching ptr+1, ptr+2, ... with wrap from N_CH-1 to 0; ptr itself is searched last.
REQ-018 ptr shall update to grant only on an input transfer; it shall hold on a stall or when no input is valid.
REQ-019 Fixed mode: grant_valid = in_valid[sel] && sel < N_CH; grant = sel; ptr shall still update on a transfer.
REQ-020 An out-of-range sel (sel >= N_CH) shall produce no grant and no transfer; the block shall not stall permanently once sel returns to range.
REQ-021 Latency: a beat transferred at edge t shall appear on out_data/out_ch with out_valid=1 after edge t.
REQ-022 On a load cycle with no grant, out_valid shall go to 0 at the next edge.
REQ-023 Simultaneous output transfer and input transfer in one cycle shall sustain one beat per cycle with no bubble.
REQ-024 While out_valid=1 && out_ready=0, out_data and out_ch shall hold stable and all in_ready bits shall be 0.
REQ-025 Changes to mode or sel take effect combinationally in the same cycle; a beat already registered is not affected.
REQ-026 The in_ready outputs shall not depend combinationally on in_data.

Reset
REQ-027 While rst_n=0: out_valid=0, out_data=0, out_ch=0, and ptr=N_CH-1, so channel 0 has first priority after reset.
REQ-028 Reset asserted mid-transfer shall discard the registered beat immediately, without waiting for a clock edge.
REQ-029 in_ready shall be all-zero while rst_n=0.

Structure
REQ-030 Package rr_mux_pkg shall hold the MODE_RR=1'b0 and MODE_FIXED=1'b1 constants and the default N_CH and DATA_W values.
REQ-031 Sub-module rr_arbiter (parameter N_CH; inputs req, ptr, mode, sel; outputs grant, grant_valid) shall be purely combinational; ptr and the output register stay in rr_mux.

Verification (N_CH=4, DATA_W=8)
REQ-032 Reset, then in_valid=4'b1111 with data A0/B1/C2/D3 on ch0..3, mode=0, out_ready=1 -> outputs A0,B1,C2,D3,A0 on consecutive cycles with out_ch 0,1,2,3,0.
REQ-033 mode=1, sel=2, all channels valid -> only in_ready[2] is ever high; every out_data equals ch2 data; out_ch=2.
REQ-034 out_ready=0 for 3 cycles with out_valid=1, value 8'h5A -> 8'h5A held, in_ready=0; release -> next beat follows with no bubble.
REQ-035 in_valid=4'b0100 only, after a grant of ch3 -> ch2 is granted (wrap past 0 and 1); then in_valid=0 -> out_valid drops after one edge.
REQ-036 rst_n pulsed low asynchronously between edges while out_valid=1 -> out_valid=0 immediately; first grant after release goes to ch0.
REQ-037 Every run: a checker asserts at most one in_ready bit is high, and the sequence of transfers equals the sequence of input transfers (no loss, no duplication).
